// File: rtl/line_burst_adapter_pkg.sv
// Shared constants, state type and line-address helper for the line-to-burst adapter.
package line_burst_adapter_pkg;

    localparam int ADDR_W        = 32;
    localparam int LINE_W        = 256;
    localparam int BEAT_W        = 64;
    localparam int BEATS         = LINE_W / BEAT_W;
    localparam int CNT_W         = $clog2(BEATS);
    localparam int LINE_OFFSET_W = 5;

    typedef enum logic [2:0] {
        IDLE,
        RD_ISSUE,
        RD_COLLECT,
        WR_BURST,
        DONE
    } line_adapter_state_t;

    function automatic logic [ADDR_W-1:0] line_addr(input logic [ADDR_W-1:0] addr);
        return {addr[ADDR_W-1:LINE_OFFSET_W], {LINE_OFFSET_W{1'b0}}};
    endfunction

endpackage

// File: rtl/line_burst_adapter_if.sv
// Upstream cacheline port and downstream banked-memory burst port of the adapter.
interface line_burst_adapter_if;
    import line_burst_adapter_pkg::*;

    logic [ADDR_W-1:0] mem_addr;
    logic              mem_read;
    logic              mem_write;
    logic [LINE_W-1:0] mem_wdata;
    logic [LINE_W-1:0] mem_rdata;
    logic              mem_resp;
    logic [ADDR_W-1:0] mem_raddr;

    logic [ADDR_W-1:0] bmem_addr;
    logic              bmem_read;
    logic              bmem_write;
    logic [BEAT_W-1:0] bmem_wdata;
    logic              bmem_ready;
    logic [ADDR_W-1:0] bmem_raddr;
    logic [BEAT_W-1:0] bmem_rdata;
    logic              bmem_rvalid;

    // The adapter itself.
    modport slave (
        input  mem_addr, mem_read, mem_write, mem_wdata,
        input  bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid,
        output mem_rdata, mem_resp, mem_raddr,
        output bmem_addr, bmem_read, bmem_write, bmem_wdata
    );

    // The surrounding prefetcher and memory.
    modport master (
        output mem_addr, mem_read, mem_write, mem_wdata,
        output bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid,
        input  mem_rdata, mem_resp, mem_raddr,
        input  bmem_addr, bmem_read, bmem_write, bmem_wdata
    );

endinterface

// File: rtl/line_burst_adapter_line_assembler.sv
// Beat-indexed line register: collects returning read beats into one cacheline.
module line_assembler #(
    parameter int BEAT_W = 64,
    parameter int BEATS  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     wr_en,
    input  logic [$clog2(BEATS)-1:0] wr_idx,
    input  logic [BEAT_W-1:0]        wr_data,
    output logic [BEATS*BEAT_W-1:0]  line
);

    logic [BEATS-1:0][BEAT_W-1:0] beat_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_q <= '0;
        end else if (clear) begin
            beat_q <= '0;
        end else if (wr_en) begin
            beat_q[wr_idx] <= wr_data;
        end
    end

    assign line = beat_q;

endmodule

// File: rtl/line_burst_adapter.sv
// Converts 256-bit cacheline reads/writes into 64-bit beats on a banked-memory port.
// Write path is built only when LINE_ADAPTER_WRITE_EN is defined.
module line_burst_adapter
    import line_burst_adapter_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    line_burst_adapter_if.slave bus
);

    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    line_adapter_state_t state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q;
    logic [ADDR_W-1:0]   raddr_q;
    logic                resp_q;
    logic                start_rd;
    logic                start_wr;
    logic                beat_hit;
    logic [LINE_W-1:0]   line_q;
    logic                unused_sink;

`ifdef LINE_ADAPTER_WRITE_EN
    logic [BEATS-1:0][BEAT_W-1:0] wdata_q;
`endif

    // Only beats for the line in flight count; stray or stale beats are dropped.
    assign beat_hit = (state_q == RD_COLLECT) && bus.bmem_rvalid &&
                      (bus.bmem_raddr[ADDR_W-1:LINE_OFFSET_W] == addr_q[ADDR_W-1:LINE_OFFSET_W]);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        start_rd = 1'b0;
        start_wr = 1'b0;
        case (state_q)
            IDLE: begin
`ifdef LINE_ADAPTER_WRITE_EN
                if (bus.mem_write) begin
                    start_wr = 1'b1;
                    state_d  = WR_BURST;
                end else if (bus.mem_read) begin
                    start_rd = 1'b1;
                    state_d  = RD_ISSUE;
                end
`else
                if (bus.mem_read) begin
                    start_rd = 1'b1;
                    state_d  = RD_ISSUE;
                end
`endif
            end
            RD_ISSUE: begin
                if (bus.bmem_ready) begin
                    state_d = RD_COLLECT;
                end
            end
            RD_COLLECT: begin
                if (beat_hit) begin
                    if (cnt_q == LAST_BEAT) begin
                        cnt_d   = '0;
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
`ifdef LINE_ADAPTER_WRITE_EN
            WR_BURST: begin
                if (bus.bmem_ready) begin
                    if (cnt_q == LAST_BEAT) begin
                        cnt_d   = '0;
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
`endif
            // The request is still held here; it is only resampled back in IDLE.
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            raddr_q <= '0;
            resp_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            resp_q  <= (state_d == DONE);
            if (start_rd || start_wr) begin
                addr_q <= line_addr(bus.mem_addr);
            end
            if (state_d == DONE) begin
                raddr_q <= addr_q;
            end
        end
    end

`ifdef LINE_ADAPTER_WRITE_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wdata_q <= '0;
        end else if (start_wr) begin
            wdata_q <= bus.mem_wdata;
        end
    end

    assign bus.bmem_write = (state_q == WR_BURST);
    assign bus.bmem_wdata = (state_q == WR_BURST) ? wdata_q[cnt_q] : '0;
    assign unused_sink    = ^bus.bmem_raddr[LINE_OFFSET_W-1:0];
`else
    assign bus.bmem_write = 1'b0;
    assign bus.bmem_wdata = '0;
    assign unused_sink    = ^{bus.bmem_raddr[LINE_OFFSET_W-1:0], bus.mem_write, bus.mem_wdata};
`endif

    line_assembler #(
        .BEAT_W (BEAT_W),
        .BEATS  (BEATS)
    ) u_line_assembler (
        .clk     (clk),
        .rst     (rst),
        .clear   (start_rd),
        .wr_en   (beat_hit),
        .wr_idx  (cnt_q),
        .wr_data (bus.bmem_rdata),
        .line    (line_q)
    );

    assign bus.bmem_read = (state_q == RD_ISSUE);
    assign bus.bmem_addr = ((state_q == RD_ISSUE) || (state_q == WR_BURST)) ? addr_q : '0;
    assign bus.mem_resp  = resp_q;
    assign bus.mem_raddr = raddr_q;
    assign bus.mem_rdata = line_q;

endmodule

// File: tb/tb_line_burst_adapter.sv
// Scoreboard bench for line_burst_adapter: directed reads, gaps, stray beats, writes, reset.
module tb_line_burst_adapter;

    typedef struct {
        logic [255:0] rdata;
        logic [31:0]  raddr;
    } resp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    line_burst_adapter_if bus();

    line_burst_adapter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    resp_t        exp_resp[$];
    logic [31:0]  exp_issue[$];
    logic [63:0]  exp_beat[$];
    logic [255:0] last_line = '0;
    int           n_cmp = 0;
    int           n_err = 0;
    bit           prev_resp = 1'b0;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic fail(input string nm);
        n_cmp++;
        n_err++;
        $display("FAIL %s: event not seen within cycle budget", nm);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops expectations whenever the DUT completes, issues or has a beat accepted.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.mem_resp) begin
                chk("resp_single_pulse", {255'd0, prev_resp}, 256'd0);
                if (exp_resp.size() == 0) begin
                    fail("unexpected_mem_resp");
                end else begin
                    resp_t e;
                    e = exp_resp.pop_front();
                    chk("resp_rdata", bus.mem_rdata, e.rdata);
                    chk("resp_raddr", {224'd0, bus.mem_raddr}, {224'd0, e.raddr});
                end
            end
            if (bus.bmem_read && bus.bmem_ready) begin
                if (exp_issue.size() == 0) fail("unexpected_bmem_read");
                else chk("issue_addr", {224'd0, bus.bmem_addr}, {224'd0, exp_issue.pop_front()});
            end
            if (bus.bmem_write && bus.bmem_ready) begin
                if (exp_beat.size() == 0) fail("unexpected_bmem_write");
                else chk("write_beat", {192'd0, bus.bmem_wdata}, {192'd0, exp_beat.pop_front()});
            end
        end
        prev_resp = bus.mem_resp;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wait_resp(input string nm, output int cycles);
        bit seen = 1'b0;
        cycles = 0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clk);
            cycles++;
            seen = bus.mem_resp;
        end
        if (!seen) fail(nm);
    endtask

    // Presents a read request, optionally stalling bmem_ready with a stray beat, and waits for the issue.
    task automatic rd_issue(input logic [31:0] addr, input int stall);
        bit ok = 1'b0;
        exp_issue.push_back(addr & 32'hFFFF_FFE0);
        bus.mem_addr = addr;
        bus.mem_read = 1'b1;
        if (stall > 0) begin
            bus.bmem_ready  = 1'b0;
            bus.bmem_rvalid = 1'b1;
            bus.bmem_raddr  = addr & 32'hFFFF_FFE0;
            bus.bmem_rdata  = 64'hDEAD_BEEF_DEAD_BEEF;
            repeat (stall) tick();
            bus.bmem_rvalid = 1'b0;
        end
        bus.bmem_ready = 1'b1;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            ok = bus.bmem_read && bus.bmem_ready;
        end
        if (!ok) fail("read_issue");
        tick();
    endtask

    // Drives n beat slots: vmask marks valid slots, wmask marks valid slots with a foreign address.
    task automatic rd_collect(input logic [31:0] addr, input logic [255:0] line,
                              input int n, input logic [15:0] vmask, input logic [15:0] wmask);
        resp_t r;
        int    k = 0;
        r.rdata = line;
        r.raddr = addr & 32'hFFFF_FFE0;
        exp_resp.push_back(r);
        last_line = line;
        for (int i = 0; i < n; i++) begin
            bus.bmem_rvalid = vmask[i];
            bus.bmem_raddr  = addr & 32'hFFFF_FFE0;
            bus.bmem_rdata  = 64'h0BAD_0BAD_0BAD_0BAD;
            if (vmask[i] && wmask[i]) begin
                bus.bmem_raddr = 32'h0000_2000;
            end else if (vmask[i]) begin
                bus.bmem_rdata = line[k*64 +: 64];
                k++;
            end
            tick();
        end
        bus.bmem_rvalid = 1'b0;
        @(negedge clk);
        chk("resp_after_last_beat", {255'd0, bus.mem_resp}, 256'd1);
        bus.mem_read = 1'b0;
        tick();
    endtask

    localparam logic [255:0] LINE_A = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                       64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    localparam logic [255:0] LINE_B = {64'hB3B3_0000_0000_0003, 64'hB2B2_0000_0000_0002,
                                       64'hB1B1_0000_0000_0001, 64'hB0B0_0000_0000_0000};
    localparam logic [255:0] LINE_C = {64'hC3C3_C3C3_1234_5678, 64'hC2C2_C2C2_1234_5678,
                                       64'hC1C1_C1C1_1234_5678, 64'hC0C0_C0C0_1234_5678};
    localparam logic [255:0] LINE_D = {64'hD3D3_0101_0101_0101, 64'hD2D2_0101_0101_0101,
                                       64'hD1D1_0101_0101_0101, 64'hD0D0_0101_0101_0101};

    initial begin
        int           cyc;
        logic [255:0] wd;
        bus.mem_addr    = '0;
        bus.mem_read    = 1'b0;
        bus.mem_write   = 1'b0;
        bus.mem_wdata   = '0;
        bus.bmem_ready  = 1'b0;
        bus.bmem_raddr  = '0;
        bus.bmem_rdata  = '0;
        bus.bmem_rvalid = 1'b0;

        tick();
        tick();
        @(negedge clk);
        chk("rst_mem_resp",   {255'd0, bus.mem_resp},   256'd0);
        chk("rst_mem_rdata",  bus.mem_rdata,            256'd0);
        chk("rst_mem_raddr",  {224'd0, bus.mem_raddr},  256'd0);
        chk("rst_bmem_addr",  {224'd0, bus.bmem_addr},  256'd0);
        chk("rst_bmem_read",  {255'd0, bus.bmem_read},  256'd0);
        chk("rst_bmem_write", {255'd0, bus.bmem_write}, 256'd0);
        chk("rst_bmem_wdata", {192'd0, bus.bmem_wdata}, 256'd0);
        tick();
        rst = 1'b0;
        tick();

        // Read, back-to-back beats.
        rd_issue(32'h0000_1234, 0);
        rd_collect(32'h0000_1234, LINE_A, 4, 16'h000F, 16'h0000);

        // Read, rvalid pattern 1,0,0,1,1,0,1.
        rd_issue(32'h0000_1234, 0);
        rd_collect(32'h0000_1234, LINE_A, 7, 16'b1011001, 16'h0000);

        // Issue stalled with a stray beat, then a foreign-address beat mid-burst.
        rd_issue(32'h0000_1234, 2);
        rd_collect(32'h0000_1234, LINE_B, 5, 16'b11111, 16'b00100);

`ifdef LINE_ADAPTER_WRITE_EN
        // Write with bmem_ready low for two cycles on beat 1.
        wd = {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
              64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
        for (int i = 0; i < 4; i++) exp_beat.push_back(wd[i*64 +: 64]);
        begin
            resp_t r;
            r.rdata = last_line;
            r.raddr = 32'h0000_8000;
            exp_resp.push_back(r);
        end
        bus.mem_addr   = 32'h0000_8010;
        bus.mem_wdata  = wd;
        bus.mem_write  = 1'b1;
        bus.bmem_ready = 1'b1;
        tick();
        tick();
        bus.bmem_ready = 1'b0;
        @(negedge clk);
        chk("wr_hold_beat1_a", {192'd0, bus.bmem_wdata}, {192'd0, 64'hBBBB_BBBB_BBBB_BBBB});
        chk("wr_hold_valid_a", {255'd0, bus.bmem_write}, 256'd1);
        tick();
        @(negedge clk);
        chk("wr_hold_beat1_b", {192'd0, bus.bmem_wdata}, {192'd0, 64'hBBBB_BBBB_BBBB_BBBB});
        chk("wr_hold_addr",    {224'd0, bus.bmem_addr},  {224'd0, 32'h0000_8000});
        tick();
        bus.bmem_ready = 1'b1;
        wait_resp("wr_resp", cyc);
        chk("wr_stall_latency", cyc, 256'd4);
        bus.mem_write = 1'b0;
        tick();

        // Write and read together: write first, read only after DONE.
        wd = {64'h0303_0303_0303_0303, 64'h0202_0202_0202_0202,
              64'h0101_0101_0101_0101, 64'h0000_0000_0000_00FF};
        for (int i = 0; i < 4; i++) exp_beat.push_back(wd[i*64 +: 64]);
        begin
            resp_t r;
            r.rdata = last_line;
            r.raddr = 32'h0000_4A40;
            exp_resp.push_back(r);
        end
        bus.mem_addr  = 32'h0000_4A5C;
        bus.mem_wdata = wd;
        bus.mem_write = 1'b1;
        bus.mem_read  = 1'b1;
        wait_resp("wr_rd_write_resp", cyc);
        chk("wr_latency", cyc, 256'd6);
        chk("wr_rd_no_issue_in_done", {255'd0, bus.bmem_read}, 256'd0);
        bus.mem_write = 1'b0;
        @(negedge clk);
        chk("wr_rd_no_issue_in_idle", {255'd0, bus.bmem_read}, 256'd0);
        rd_issue(32'h0000_4A5C, 0);
        rd_collect(32'h0000_4A5C, LINE_C, 4, 16'h000F, 16'h0000);
`else
        // Write path absent: a lone write is ignored.
        bus.mem_addr  = 32'h0000_8010;
        bus.mem_wdata = {4{64'hA5A5_A5A5_A5A5_A5A5}};
        bus.mem_write = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("wr_dis_bmem_write", {255'd0, bus.bmem_write}, 256'd0);
            chk("wr_dis_bmem_wdata", {192'd0, bus.bmem_wdata}, 256'd0);
            chk("wr_dis_no_resp",    {255'd0, bus.mem_resp},   256'd0);
        end
        tick();
        // Write and read together: only the read is serviced.
        rd_issue(32'h0000_4A5C, 0);
        rd_collect(32'h0000_4A5C, LINE_C, 4, 16'h000F, 16'h0000);
        bus.mem_write = 1'b0;
        tick();
`endif

        // Asynchronous reset after two beats of a read.
        rd_issue(32'h0000_5678, 0);
        bus.bmem_rvalid = 1'b1;
        bus.bmem_raddr  = 32'h0000_5660;
        bus.bmem_rdata  = 64'h5555_0000_0000_0000;
        tick();
        bus.bmem_rdata  = 64'h5555_0000_0000_0001;
        tick();
        bus.bmem_rvalid = 1'b0;
        #2;
        rst          = 1'b1;
        bus.mem_read = 1'b0;
        #1;
        chk("async_rst_mem_rdata", bus.mem_rdata,           256'd0);
        chk("async_rst_mem_raddr", {224'd0, bus.mem_raddr}, 256'd0);
        chk("async_rst_mem_resp",  {255'd0, bus.mem_resp},  256'd0);
        chk("async_rst_bmem_read", {255'd0, bus.bmem_read}, 256'd0);
        tick();
        rst = 1'b0;
        bus.bmem_rvalid = 1'b1;
        bus.bmem_rdata  = 64'h5555_0000_0000_0002;
        tick();
        bus.bmem_rdata  = 64'h5555_0000_0000_0003;
        tick();
        bus.bmem_rvalid = 1'b0;
        repeat (3) tick();

        rd_issue(32'h0000_5678, 0);
        rd_collect(32'h0000_5678, LINE_D, 4, 16'h000F, 16'h0000);

        repeat (5) tick();
        chk("pending_resp",  exp_resp.size(),  256'd0);
        chk("pending_issue", exp_issue.size(), 256'd0);
        chk("pending_beats", exp_beat.size(),  256'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
